knopf_entpreller: RTL



---
 rtl/knopf_entpreller.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/knopf_entpreller.sv
// Push-button debouncer with sticky press/release flags, read by the CPU through a DatenGeladen handshake.
// Release flags exist only when KNOPF_LOSLASSEN_EN is defined.
module knopf_entpreller #(
   parameter int ANZAHL         = 7,
   parameter int ENTPRELLZYKLEN = 1048576
) (
   input  logic              Clock,
   input  logic              Reset,
   input  logic [ANZAHL-1:0] btn,
   input  logic              Lesen,
   input  logic [1:0]        Auswahl,
   output logic [31:0]       Daten,
   output logic              DatenGeladen,
   output logic [ANZAHL-1:0] Pegel
);

   localparam int ZW = $clog2(ENTPRELLZYKLEN + 1);
   localparam logic [ZW-1:0] ZIEL = ZW'(ENTPRELLZYKLEN - 1);

   typedef enum logic [1:0] {
      BEREIT  = 2'd0,
      ANTWORT = 2'd1,
      WARTEN  = 2'd2
   } zustand_t;

   zustand_t          zustand_r, zustand_s;
   logic [ANZAHL-1:0] sync1_r, sync2_r;
   logic [ZW-1:0]     zaehler_r [ANZAHL];
   logic [ZW-1:0]     zaehler_s [ANZAHL];
   logic [ANZAHL-1:0] pegel_s;
   logic [ANZAHL-1:0] steigend_s;
   logic [ANZAHL-1:0] gedrueckt_r;
   logic              laden_s;
   logic              clr_ged_s;
   logic [31:0]       lese_daten_s;
`ifdef KNOPF_LOSLASSEN_EN
   logic [ANZAHL-1:0] fallend_s;
   logic [ANZAHL-1:0] losgelassen_r;
   logic              clr_los_s;
`endif

   // Per-button stability counters; a level flips after ENTPRELLZYKLEN differing samples
   always_comb begin
      pegel_s = Pegel;
      for (int i = 0; i < ANZAHL; i++) begin
         if (sync2_r[i] == Pegel[i]) begin
            zaehler_s[i] = '0;
         end else if (zaehler_r[i] == ZIEL) begin
            zaehler_s[i] = '0;
            pegel_s[i]   = ~Pegel[i];
         end else begin
            zaehler_s[i] = zaehler_r[i] + ZW'(1);
         end
      end
      steigend_s = pegel_s & ~Pegel;
`ifdef KNOPF_LOSLASSEN_EN
      fallend_s  = Pegel & ~pegel_s;
`endif
   end

   // Synchronizer, debounce state and press flags (a new edge beats a same-cycle clear)
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         sync1_r     <= '0;
         sync2_r     <= '0;
         Pegel       <= '0;
         gedrueckt_r <= '0;
         for (int i = 0; i < ANZAHL; i++) begin
            zaehler_r[i] <= '0;
         end
      end else begin
         sync1_r     <= btn;
         sync2_r     <= sync1_r;
         Pegel       <= pegel_s;
         gedrueckt_r <= (gedrueckt_r & ~{ANZAHL{clr_ged_s}}) | steigend_s;
         for (int i = 0; i < ANZAHL; i++) begin
            zaehler_r[i] <= zaehler_s[i];
         end
      end
   end

`ifdef KNOPF_LOSLASSEN_EN
   // Sticky release flags
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         losgelassen_r <= '0;
      end else begin
         losgelassen_r <= (losgelassen_r & ~{ANZAHL{clr_los_s}}) | fallend_s;
      end
   end
`endif

   // Read FSM state register
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         zustand_r <= BEREIT;
      end else begin
         zustand_r <= zustand_s;
      end
   end

   // Read FSM next state: a held Lesen parks in WARTEN so it counts as a single read
   always_comb begin
      zustand_s = zustand_r;
      case (zustand_r)
         BEREIT:  zustand_s = Lesen ? ANTWORT : BEREIT;
         ANTWORT: zustand_s = Lesen ? WARTEN  : BEREIT;
         WARTEN:  zustand_s = Lesen ? WARTEN  : BEREIT;
         default: zustand_s = BEREIT;
      endcase
   end

   // Read FSM outputs: source select and clear-on-read strobes
   always_comb begin
      laden_s      = (zustand_r == BEREIT) && Lesen;
      lese_daten_s = 32'd0;
      clr_ged_s    = 1'b0;
`ifdef KNOPF_LOSLASSEN_EN
      clr_los_s    = 1'b0;
`endif
      case (Auswahl)
         2'd0: lese_daten_s[ANZAHL-1:0] = Pegel;
         2'd1: begin
            lese_daten_s[ANZAHL-1:0] = gedrueckt_r;
            clr_ged_s                = laden_s;
         end
`ifdef KNOPF_LOSLASSEN_EN
         2'd2: begin
            lese_daten_s[ANZAHL-1:0] = losgelassen_r;
            clr_los_s                = laden_s;
         end
`endif
         default: lese_daten_s = 32'd0;
      endcase
   end

   // Registered read data and one-cycle DatenGeladen pulse
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         Daten        <= 32'd0;
         DatenGeladen <= 1'b0;
      end else begin
         DatenGeladen <= laden_s;
         if (laden_s) begin
            Daten <= lese_daten_s;
         end else begin
            Daten <= Daten;
         end
      end
   end

endmodule
